// File: rtl/aes_inv_rcon.sv
// aes_inv_rcon: inverse round-constant generator for the AES decryption key
// schedule. Walks the rcon sequence backwards, from the last round constant
// down to 0x01, one step per advance request. Each step divides the current
// constant by x in GF(2^8); no lookup table is used.
//
// Ports:
//   clk    - clock, all state updates on posedge
//   rst_n  - asynchronous active-low reset
//   kld    - load/restart at the last constant (priority over adv)
//   adv    - advance one step toward 0x01
//   out    - {rcon_byte, 24'h000000}
//   valid  - out holds a live constant
//   last   - out is the final constant (0x01000000)
//   rnd    - index of the constant on out (NUM_RCON-1 down to 0)
module aes_inv_rcon #(
  parameter int NUM_RCON = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kld,
  input  logic        adv,
  output logic [31:0] out,
  output logic        valid,
  output logic        last,
  output logic [3:0]  rnd
);

  if (NUM_RCON < 1 || NUM_RCON > 10) begin : g_param_check
    $error("aes_inv_rcon: NUM_RCON must be in 1..10");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Divide by x modulo the AES polynomial: an odd value first has the
  // reduction term folded back in, which sets the bit shifted in at the top.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    logic [7:0] t;
    t = b ^ 8'h1b;
    return b[0] ? {1'b1, t[7:1]} : {1'b0, b[7:1]};
  endfunction

  // Last constant of the forward sequence, evaluated at elaboration.
  function automatic logic [7:0] start_const();
    logic [7:0] c;
    c = 8'h01;
    for (int i = 0; i < NUM_RCON - 1; i++) begin
      c = xtime(c);
    end
    return c;
  endfunction

  localparam logic [7:0] START   = start_const();
  localparam logic [3:0] RND_TOP = 4'(NUM_RCON - 1);
  localparam logic       LAST_AT_LOAD = (NUM_RCON == 1) ? 1'b1 : 1'b0;

  state_t     state, state_nxt;
  logic [7:0] rc_byte, rc_byte_nxt;
  logic [3:0] rnd_nxt;
  logic       valid_nxt, last_nxt;

  // Next-state and next-output logic; kld always wins over adv.
  always_comb begin
    state_nxt   = state;
    rc_byte_nxt = rc_byte;
    rnd_nxt     = rnd;
    valid_nxt   = valid;
    last_nxt    = last;
    if (kld) begin
      state_nxt   = RUN;
      rc_byte_nxt = START;
      rnd_nxt     = RND_TOP;
      valid_nxt   = 1'b1;
      last_nxt    = LAST_AT_LOAD;
    end else if (adv) begin
      case (state)
        RUN: begin
          if (rnd != 4'd0) begin
            rc_byte_nxt = inv_xtime(rc_byte);
            rnd_nxt     = rnd - 4'd1;
            last_nxt    = (rnd == 4'd1) ? 1'b1 : 1'b0;
          end else begin
            // Sequence exhausted: only kld can restart it.
            state_nxt   = IDLE;
            rc_byte_nxt = 8'h00;
            rnd_nxt     = 4'd0;
            valid_nxt   = 1'b0;
            last_nxt    = 1'b0;
          end
        end
        IDLE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt   = IDLE;
          rc_byte_nxt = 8'h00;
          rnd_nxt     = 4'd0;
          valid_nxt   = 1'b0;
          last_nxt    = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rc_byte <= 8'h00;
      rnd     <= 4'd0;
      valid   <= 1'b0;
      last    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rc_byte <= rc_byte_nxt;
      rnd     <= rnd_nxt;
      valid   <= valid_nxt;
      last    <= last_nxt;
    end
  end

  assign out = {rc_byte, 24'h000000};

endmodule

// File: tb/tb_aes_inv_rcon.sv
// Testbench for aes_inv_rcon: a NUM_RCON=10 and a NUM_RCON=7 instance share
// stimulus. A reference model built on the forward rcon list (read in
// reverse) pushes expected outputs into per-instance queues at drive time;
// they are popped and compared one cycle later. A vector table covers the
// full default sequence, with hand-written sequences for the corner cases.
module tb_aes_inv_rcon;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kld = 1'b0;
  logic        adv = 1'b0;
  logic [31:0] out10, out7;
  logic        valid10, valid7, last10, last7;
  logic [3:0]  rnd10, rnd7;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_inv_rcon #(.NUM_RCON(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .kld(kld), .adv(adv),
    .out(out10), .valid(valid10), .last(last10), .rnd(rnd10)
  );

  aes_inv_rcon #(.NUM_RCON(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .kld(kld), .adv(adv),
    .out(out7), .valid(valid7), .last(last7), .rnd(rnd7)
  );

  typedef struct {
    logic       valid;
    logic [3:0] rnd;
  } mst_t;

  typedef struct {
    logic        kld;
    logic        adv;
    logic [31:0] out;
    logic [3:0]  rnd;
    logic        last;
    logic        valid;
  } vec_t;

  logic [7:0]  fwd [10];
  mst_t        m10, m7;
  logic [37:0] q10[$];
  logic [37:0] q7[$];

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    logic [8:0] w;
    w = {b, 1'b0};
    if (w[8]) w = w ^ 9'h11b;
    return w[7:0];
  endfunction

  function automatic mst_t mstep(input mst_t s, input int n, input logic k, input logic a);
    mst_t r;
    r = s;
    if (k) begin
      r.valid = 1'b1;
      r.rnd   = 4'(n - 1);
    end else if (a && s.valid) begin
      if (s.rnd > 4'd0) r.rnd = s.rnd - 4'd1;
      else begin
        r.valid = 1'b0;
        r.rnd   = 4'd0;
      end
    end
    return r;
  endfunction

  // Packed expectation {out, valid, last, rnd}.
  function automatic logic [37:0] mexp(input mst_t s);
    logic [31:0] o;
    o = s.valid ? {fwd[s.rnd], 24'h000000} : 32'h0;
    return {o, s.valid, (s.valid && s.rnd == 4'd0), (s.valid ? s.rnd : 4'd0)};
  endfunction

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got out=%h v=%b l=%b rnd=%0d, required out=%h v=%b l=%b rnd=%0d",
               name, act[37:6], act[5], act[4], act[3:0], exp[37:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  function automatic logic [37:0] dut10_bus();
    return {out10, valid10, last10, rnd10};
  endfunction

  function automatic logic [37:0] dut7_bus();
    return {out7, valid7, last7, rnd7};
  endfunction

  // One clock of stimulus; the scoreboard entries are checked after the edge.
  task automatic step(input logic k, input logic a, input string name);
    @(negedge clk);
    kld = k;
    adv = a;
    m10 = mstep(m10, 10, k, a);
    m7  = mstep(m7, 7, k, a);
    q10.push_back(mexp(m10));
    q7.push_back(mexp(m7));
    @(posedge clk);
    #1;
    chk({name, "/n10"}, dut10_bus(), q10.pop_front());
    chk({name, "/n7"},  dut7_bus(),  q7.pop_front());
  endtask

  vec_t tbl [12];

  initial begin
    fwd[0] = 8'h01;
    for (int i = 1; i < 10; i++) fwd[i] = tb_xtime(fwd[i-1]);
    m10 = '{valid: 1'b0, rnd: 4'd0};
    m7  = '{valid: 1'b0, rnd: 4'd0};

    tbl[0]  = '{1'b1, 1'b0, 32'h36000000, 4'd9, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'h1b000000, 4'd8, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 32'h80000000, 4'd7, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 32'h40000000, 4'd6, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'h20000000, 4'd5, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h10000000, 4'd4, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h08000000, 4'd3, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 32'h04000000, 4'd2, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'h02000000, 4'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h01000000, 4'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'h00000000, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h00000000, 4'd0, 1'b0, 1'b0};

    // Scenario 1: reset values, then idle after release.
    #12;
    chk("in_reset", dut10_bus(), 38'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "idle");
    chk("idle_const", dut10_bus(), 38'h0);

    // Scenario 2: full default sequence from the table.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].kld, tbl[i].adv, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_const", i), dut10_bus(),
          {tbl[i].out, tbl[i].valid, tbl[i].last, tbl[i].rnd});
    end

    // Scenario 3: adv with 0-3 idle cycles between steps.
    step(1'b1, 1'b0, "gap_kld");
    for (int i = 0; i < 11; i++) begin
      int gap;
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, "gap_hold");
      step(1'b0, 1'b1, "gap_adv");
    end

    // Scenario 4: restart mid-sequence, then kld and adv together.
    step(1'b1, 1'b0, "mid_kld");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "mid_adv");
    chk("mid_at10", dut10_bus(), {32'h10000000, 1'b1, 1'b0, 4'd4});
    step(1'b1, 1'b0, "mid_reload");
    chk("mid_reload_const", dut10_bus(), {32'h36000000, 1'b1, 1'b0, 4'd9});
    step(1'b0, 1'b1, "mid_adv2");
    step(1'b1, 1'b1, "kld_adv");
    chk("kld_adv_const", dut10_bus(), {32'h36000000, 1'b1, 1'b0, 4'd9});

    // Scenario 5: NUM_RCON=7 instance end to end, then adv while idle.
    step(1'b1, 1'b0, "n7_kld");
    chk("n7_start", dut7_bus(), {32'h40000000, 1'b1, 1'b0, 4'd6});
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "n7_adv");
    chk("n7_last", dut7_bus(), {32'h01000000, 1'b1, 1'b1, 4'd0});
    step(1'b0, 1'b1, "n7_exhaust");
    step(1'b0, 1'b1, "n7_idle_adv");
    chk("n7_idle_const", dut7_bus(), 38'h0);

    // Scenario 6: asynchronous reset between edges at rnd=5.
    step(1'b1, 1'b0, "rst_kld");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "rst_adv");
    chk("rst_pre", dut10_bus(), {32'h20000000, 1'b1, 1'b0, 4'd5});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async10", dut10_bus(), 38'h0);
    chk("rst_async7", dut7_bus(), 38'h0);
    m10 = '{valid: 1'b0, rnd: 4'd0};
    m7  = '{valid: 1'b0, rnd: 4'd0};
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, "post_rst_adv");
    step(1'b1, 1'b0, "post_rst_kld");
    chk("post_rst_const", dut10_bus(), {32'h36000000, 1'b1, 1'b0, 4'd9});
    step(1'b0, 1'b0, "post_rst_hold");

    @(negedge clk);
    kld = 1'b0;
    adv = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
